// File: rtl/tick_rate_controller_if.sv
// Button inputs and tick/status outputs of the tick rate controller.
// master: the side that presses buttons and watches the tick.
// slave:  the controller itself.
interface tick_rate_controller_if;
    logic       speed_btn;
    logic       pause_btn;
    logic       step_btn;
    logic       tick;
    logic [1:0] speed_level;
    logic       running;

    modport master (
        output speed_btn,
        output pause_btn,
        output step_btn,
        input  tick,
        input  speed_level,
        input  running
    );

    modport slave (
        input  speed_btn,
        input  pause_btn,
        input  step_btn,
        output tick,
        output speed_level,
        output running
    );
endinterface

// File: rtl/tick_rate_controller.sv
// Tick rate controller: programmable-period tick generator with a four-level
// speed table and a run / pause / single-step state machine. Three raw
// pushbuttons are synchronised and rising-edge detected before use.
// Each PERIODn must be at least 2 and below 2**CNT_W.
module tick_rate_controller #(
    parameter int CNT_W   = 23,
    parameter int PERIOD0 = 1000,
    parameter int PERIOD1 = 2000,
    parameter int PERIOD2 = 4000,
    parameter int PERIOD3 = 8000
) (
    input  logic                  clk,
    input  logic                  nrst,
    tick_rate_controller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PER0_C = CNT_W'(PERIOD0);
    localparam logic [CNT_W-1:0] PER1_C = CNT_W'(PERIOD1);
    localparam logic [CNT_W-1:0] PER2_C = CNT_W'(PERIOD2);
    localparam logic [CNT_W-1:0] PER3_C = CNT_W'(PERIOD3);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    // Button bit order: [0] speed, [1] pause, [2] step.
    logic [2:0] btn_raw_s;
    logic [2:0] btn_meta_q;
    logic [2:0] btn_sync_q;
    logic [2:0] btn_prev_q;
    logic [2:0] btn_ev_s;
    logic       speed_ev_s;
    logic       pause_ev_s;
    logic       step_ev_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [1:0]       level_q, level_d;
    logic             running_q;
    logic [CNT_W-1:0] period_sel_s;
    logic [CNT_W-1:0] period_last_s;

    assign btn_raw_s  = {bus.step_btn, bus.pause_btn, bus.speed_btn};

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            btn_meta_q <= 3'b000;
            btn_sync_q <= 3'b000;
            btn_prev_q <= 3'b000;
        end else begin
            btn_meta_q <= btn_raw_s;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // One-cycle event per synchronised rising edge; a held button fires once.
    assign btn_ev_s   = btn_sync_q & ~btn_prev_q;
    assign speed_ev_s = btn_ev_s[0];
    assign pause_ev_s = btn_ev_s[1];
    assign step_ev_s  = btn_ev_s[2];

    // Period lookup for the current speed level.
    always_comb begin
        period_sel_s = PER0_C;
        case (level_q)
            2'd0:    period_sel_s = PER0_C;
            2'd1:    period_sel_s = PER1_C;
            2'd2:    period_sel_s = PER2_C;
            2'd3:    period_sel_s = PER3_C;
            default: period_sel_s = PER0_C;
        endcase
        period_last_s = period_sel_s - ONE_C;
    end

    // Next-state, counter, tick and speed-level logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        level_d = level_q;
        case (state_q)
            ST_RUN: begin
                if (pause_ev_s) begin
                    // Count is held so that resuming continues mid-period.
                    state_d = ST_PAUSED;
                end else if (count_q >= period_last_s) begin
                    // >= keeps the counter bounded even if the period shrank.
                    count_d = ZERO_C;
                    tick_d  = ~speed_ev_s;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end
            ST_PAUSED: begin
                if (pause_ev_s) begin
                    // Pause wins over a coincident step.
                    state_d = ST_RUN;
                end else if (step_ev_s) begin
                    state_d = ST_STEP;
                    tick_d  = 1'b1;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_STEP: begin
                // Single-cycle state; events seen here are dropped.
                state_d = ST_PAUSED;
            end
            default: begin
                state_d = ST_RUN;
                count_d = ZERO_C;
            end
        endcase
        // A speed change restarts the period in every state.
        if (speed_ev_s) begin
            level_d = level_q + 2'd1;
            count_d = ZERO_C;
        end else begin
            level_d = level_q;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_RUN;
            count_q   <= ZERO_C;
            tick_q    <= 1'b0;
            level_q   <= 2'd0;
            running_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign bus.tick        = tick_q;
    assign bus.speed_level = level_q;
    assign bus.running     = running_q;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Randomised scoreboard bench for tick_rate_controller with periods 4/6/8/10.
module tb_tick_rate_controller;

    localparam int P0 = 4;
    localparam int P1 = 6;
    localparam int P2 = 8;
    localparam int P3 = 10;

    localparam int MODE_RUN    = 0;
    localparam int MODE_PAUSED = 1;
    localparam int MODE_STEP   = 2;

    logic       clk  = 1'b0;
    logic       nrst = 1'b1;
    logic [2:0] btn_r = 3'b000;   // [0] speed, [1] pause, [2] step

    tick_rate_controller_if bus ();

    assign bus.speed_btn = btn_r[0];
    assign bus.pause_btn = btn_r[1];
    assign bus.step_btn  = btn_r[2];

    tick_rate_controller #(
        .CNT_W  (23),
        .PERIOD0(P0),
        .PERIOD1(P1),
        .PERIOD2(P2),
        .PERIOD3(P3)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t;
        logic [1:0] lvl;
        logic       run;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time since last tick, a mode, a level, and raw
    // button history (an edge seen at edge j acts at edge j+2).
    int       m_mode    = MODE_RUN;
    int       m_level   = 0;
    int       m_elapsed = 0;
    bit [2:0] m_h1 = 3'b000;
    bit [2:0] m_h2 = 3'b000;
    bit [2:0] m_h3 = 3'b000;
    logic     last_tick = 1'b0;

    function automatic int period_of(input int lvl);
        int tbl[4];
        tbl[0] = P0; tbl[1] = P1; tbl[2] = P2; tbl[3] = P3;
        return tbl[lvl];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = MODE_RUN;
        m_level   = 0;
        m_elapsed = 0;
        m_h1      = 3'b000;
        m_h2      = 3'b000;
        m_h3      = 3'b000;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit [2:0] ev;
        bit       t;
        int       was;
        exp_t     e;
        ev   = m_h2 & ~m_h3;
        m_h3 = m_h2;
        m_h2 = m_h1;
        m_h1 = {bus.step_btn, bus.pause_btn, bus.speed_btn};
        t    = 1'b0;
        was  = m_mode;
        if (m_mode == MODE_RUN) begin
            if (ev[1]) m_mode = MODE_PAUSED;
            else begin
                m_elapsed++;
                if (m_elapsed >= period_of(m_level)) begin
                    t = 1'b1;
                    m_elapsed = 0;
                end
            end
        end else if (m_mode == MODE_PAUSED) begin
            if (ev[1]) m_mode = MODE_RUN;
            else if (ev[2]) begin
                m_mode = MODE_STEP;
                t = 1'b1;
            end
        end else begin
            m_mode = MODE_PAUSED;
        end
        if (ev[0]) begin
            m_level   = (m_level + 1) % 4;
            m_elapsed = 0;
            if (was == MODE_RUN) t = 1'b0;
        end
        e.t   = t;
        e.lvl = 2'(m_level);
        e.run = (m_mode == MODE_RUN);
        exp_q.push_back(e);
    endtask

    // Model advances on the same edges as the DUT and clears on reset.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) model_reset();
        else       model_step();
    end

    // Monitor: compare DUT outputs with the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            last_tick = 1'b0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick",        {31'd0, bus.tick},        {31'd0, e.t});
            check("speed_level", {30'd0, bus.speed_level}, {30'd0, e.lvl});
            check("running",     {31'd0, bus.running},     {31'd0, e.run});
            check("tick_width",  {31'd0, last_tick & bus.tick}, 32'd0);
            last_tick = bus.tick;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Assert reset mid-cycle, check outputs respond immediately, release.
    task automatic do_reset();
        btn_r = 3'b000;
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rst_tick",    {31'd0, bus.tick},        32'd0);
        check("rst_level",   {30'd0, bus.speed_level}, 32'd0);
        check("rst_running", {31'd0, bus.running},     32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 nrst = 1'b1;
    endtask

    task automatic press(input int idx, input int hold, input int gap);
        btn_r[idx] = 1'b1;
        wait_cycles(hold);
        btn_r[idx] = 1'b0;
        wait_cycles(gap);
    endtask

    task automatic press_mask(input logic [2:0] mask, input int hold, input int gap);
        btn_r = mask;
        wait_cycles(hold);
        btn_r = 3'b000;
        wait_cycles(gap);
    endtask

    initial begin
        #1 nrst = 1'b0;
        #2;
        check("init_tick",    {31'd0, bus.tick},        32'd0);
        check("init_level",   {30'd0, bus.speed_level}, 32'd0);
        check("init_running", {31'd0, bus.running},     32'd1);
        @(posedge clk);
        #2 nrst = 1'b1;

        // Free run at level 0.
        wait_cycles(20);

        // Speed event lands on a level-0 wrap; held button fires once.
        do_reset();
        wait_cycles(5);
        press(0, 10, 10);
        for (int i = 0; i < 3; i++) press(0, 2, 8);

        // Pause, stay paused, resume.
        press(1, 1, 30);
        press(1, 1, 12);

        // Pause, three single steps, then pause+step together.
        press(1, 1, 6);
        for (int i = 0; i < 3; i++) press(2, 1, 4);
        press_mask(3'b110, 2, 10);

        // Step presses in RUN are ignored.
        for (int i = 0; i < 3; i++) press(2, 1, 5);

        // Level 2, pause, reset while paused, then free run.
        press(0, 1, 4);
        press(0, 1, 4);
        press(1, 1, 7);
        do_reset();
        wait_cycles(12);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 19);
            case (op)
                0:       do_reset();
                1, 2:    press(0, $urandom_range(1, 4), $urandom_range(1, 8));
                3, 4, 5: press(1, $urandom_range(1, 4), $urandom_range(1, 12));
                6, 7, 8: press(2, $urandom_range(1, 3), $urandom_range(1, 6));
                9:       press_mask(3'b110, $urandom_range(1, 3), $urandom_range(1, 6));
                10:      press_mask(3'b101, $urandom_range(1, 3), $urandom_range(1, 6));
                11:      press_mask(3'b011, $urandom_range(1, 3), $urandom_range(1, 6));
                default: wait_cycles($urandom_range(1, 12));
            endcase
        end

        wait_cycles(4);
        check("backlog", (exp_q.size() <= 1) ? 32'd0 : 32'd1, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
